// File: rtl/rc_servo_multi_pwm_pkg.sv
// Shared timing defaults and the width clamp helper for the multi-channel RC-servo PWM block.
package rc_servo_pkg;

    localparam int unsigned CLK_HZ          = 50_000_000;
    localparam int unsigned FRAME_TICKS     = CLK_HZ / 50;
    localparam int unsigned PULSE_MIN_TICKS = CLK_HZ / 1000;
    localparam int unsigned PULSE_MAX_TICKS = CLK_HZ / 500;
    localparam int unsigned PULSE_RST_TICKS = PULSE_MIN_TICKS + PULSE_MIN_TICKS / 2;
    localparam int unsigned SLEW_STEP       = 500;

    function automatic logic [31:0] clamp_width(input logic [31:0] w,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        logic [31:0] r;
        r = w;
        if (w < lo) r = lo;
        else if (w > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/rc_servo_multi_pwm_ch.sv
// One servo channel: active width register committed at frame end, optional slew, registered compare.
// Slew limiting is built only when RC_SERVO_SLEW_EN is defined.
module rc_servo_pwm_ch
    import rc_servo_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = 20,
    parameter int unsigned PULSE_RST_TICKS = rc_servo_pkg::PULSE_RST_TICKS,
    parameter int unsigned SLEW_STEP       = rc_servo_pkg::SLEW_STEP
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 commit_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] shadow_i,
    input  logic [CNT_WIDTH-1:0] ctr_i,
    output logic                 pwm_o
);

    localparam logic [CNT_WIDTH-1:0] STEP = CNT_WIDTH'(SLEW_STEP);
`ifdef RC_SERVO_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    logic [CNT_WIDTH-1:0] active_q, active_d, diff, step, slewed;
    logic                 en_q, en_d, pwm_q, pwm_d;
    logic                 up;

    always_comb begin
        up       = shadow_i > active_q;
        diff     = up ? (shadow_i - active_q) : (active_q - shadow_i);
        step     = (diff > STEP) ? STEP : diff;
        slewed   = up ? (active_q + step) : (active_q - step);
        active_d = active_q;
        en_d     = en_q;
        if (commit_i) begin
            active_d = SLEW_ON ? slewed : shadow_i;
            en_d     = en_i;
        end
        // registered compare: output trails the counter by one cycle
        pwm_d = en_q & (ctr_i < active_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            active_q <= CNT_WIDTH'(PULSE_RST_TICKS);
            en_q     <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            en_q     <= en_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rc_servo_multi_pwm.sv
// N-channel RC-servo PWM: shared frame counter, write port into clamped shadow widths, frame-boundary commit.
// Optional per-frame slew limiting is enabled with the RC_SERVO_SLEW_EN macro.
module rc_servo_multi_pwm
    import rc_servo_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CH_W            = 2,
    parameter int unsigned CNT_WIDTH       = 20,
    parameter int unsigned FRAME_TICKS     = rc_servo_pkg::FRAME_TICKS,
    parameter int unsigned PULSE_MIN_TICKS = rc_servo_pkg::PULSE_MIN_TICKS,
    parameter int unsigned PULSE_MAX_TICKS = rc_servo_pkg::PULSE_MAX_TICKS,
    parameter int unsigned PULSE_RST_TICKS = rc_servo_pkg::PULSE_RST_TICKS,
    parameter int unsigned SLEW_STEP       = rc_servo_pkg::SLEW_STEP
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [CH_W-1:0]      wr_ch_i,
    input  logic [CNT_WIDTH-1:0] wr_width_i,
    input  logic [NUM_CH-1:0]    ch_en_i,
    output logic [NUM_CH-1:0]    pwm_o,
    output logic                 frame_o,
    output logic                 clamp_o,
    output logic                 ch_err_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] PRE_LAST = CNT_WIDTH'(FRAME_TICKS - 2);

    logic [CNT_WIDTH-1:0] ctr_q, ctr_d;
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CH];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_CH];
    logic [CNT_WIDTH-1:0] width_clamped;
    logic                 frame_q, frame_d, clamp_q, clamp_d, ch_err_q, ch_err_d;
    logic                 commit, accept, ch_ok, out_of_range;

    assign commit     = (ctr_q == LAST_CNT);
    assign wr_ready_o = ~commit;
    assign accept     = wr_valid_i & ~commit;

    // index range check only exists when the index field can address past NUM_CH
    if ((2 ** CH_W) > NUM_CH) begin : g_ch_chk
        assign ch_ok = (32'(wr_ch_i) < NUM_CH);
    end else begin : g_ch_all
        assign ch_ok = 1'b1;
    end

    assign width_clamped = CNT_WIDTH'(clamp_width(32'(wr_width_i), PULSE_MIN_TICKS, PULSE_MAX_TICKS));
    assign out_of_range  = (32'(wr_width_i) < PULSE_MIN_TICKS) || (32'(wr_width_i) > PULSE_MAX_TICKS);

    always_comb begin
        ctr_d    = commit ? '0 : ctr_q + CNT_WIDTH'(1);
        frame_d  = (ctr_q == PRE_LAST);
        clamp_d  = accept & ch_ok & out_of_range;
        ch_err_d = accept & ~ch_ok;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (accept && ch_ok && (32'(wr_ch_i) == i))
                shadow_d[i] = width_clamped;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_q    <= '0;
            frame_q  <= 1'b0;
            clamp_q  <= 1'b0;
            ch_err_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= CNT_WIDTH'(PULSE_RST_TICKS);
        end else begin
            ctr_q    <= ctr_d;
            frame_q  <= frame_d;
            clamp_q  <= clamp_d;
            ch_err_q <= ch_err_d;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign frame_o  = frame_q;
    assign clamp_o  = clamp_q;
    assign ch_err_o = ch_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rc_servo_pwm_ch #(
            .CNT_WIDTH      (CNT_WIDTH),
            .PULSE_RST_TICKS(PULSE_RST_TICKS),
            .SLEW_STEP      (SLEW_STEP)
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .commit_i(commit),
            .en_i    (ch_en_i[g]),
            .shadow_i(shadow_q[g]),
            .ctr_i   (ctr_q),
            .pwm_o   (pwm_o[g])
        );
    end

endmodule

// File: tb/tb_rc_servo_multi_pwm.sv
// Scoreboard bench for rc_servo_multi_pwm: expected per-frame pulse shapes queued at commit, checked at frame end.
module tb_rc_servo_multi_pwm;

    localparam int NCH = 4, CHW = 3, CW = 8;
    localparam int FT = 100, PMIN = 10, PMAX = 20, PRST = 15, STEP = 2;

    logic            clk_i = 1'b0, reset_i = 1'b1, wr_valid_i = 1'b0;
    logic [CHW-1:0]  wr_ch_i = '0;
    logic [CW-1:0]   wr_width_i = '0;
    logic [NCH-1:0]  ch_en_i = '1;
    logic            wr_ready_o, frame_o, clamp_o, ch_err_o;
    logic [NCH-1:0]  pwm_o;

    rc_servo_multi_pwm #(
        .NUM_CH(NCH), .CH_W(CHW), .CNT_WIDTH(CW), .FRAME_TICKS(FT),
        .PULSE_MIN_TICKS(PMIN), .PULSE_MAX_TICKS(PMAX), .PULSE_RST_TICKS(PRST), .SLEW_STEP(STEP)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_ch_i(wr_ch_i), .wr_width_i(wr_width_i), .ch_en_i(ch_en_i), .pwm_o(pwm_o),
        .frame_o(frame_o), .clamp_o(clamp_o), .ch_err_o(ch_err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // reference model
    int             m_ctr;
    int             m_sh [NCH];
    int             m_act[NCH];
    logic [NCH-1:0] m_en;
    logic [31:0]    sb_q[$];
    int             cnt[NCH], first[NCH], last[NCH];
    logic           pend_clamp, pend_err;

    function automatic int clampw(input int w);
        return (w < PMIN) ? PMIN : (w > PMAX) ? PMAX : w;
    endfunction

    function automatic int next_act(input int a, input int s);
`ifdef RC_SERVO_SLEW_EN
        int d;
        d = (s > a) ? s - a : a - s;
        if (d > STEP) d = STEP;
        return (s > a) ? a + d : a - d;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] frame_rec();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[8*i +: 8] = m_en[i] ? 8'(m_act[i]) : 8'd0;
        return r;
    endfunction

    always @(posedge clk_i or posedge reset_i)
        if (reset_i) m_ctr <= 0;
        else         m_ctr <= (m_ctr == FT - 1) ? 0 : m_ctr + 1;

    always @(negedge clk_i) begin : mon
        int          ch;
        logic [31:0] rec;
        logic [7:0]  w;
        if (reset_i) begin
            for (int i = 0; i < NCH; i++) begin
                m_sh[i] = PRST; m_act[i] = PRST; cnt[i] = 0; first[i] = 0; last[i] = 0;
            end
            m_en = '0;
            pend_clamp = 1'b0;
            pend_err   = 1'b0;
            sb_q.delete();
            sb_q.push_back(frame_rec());
        end else begin
            chk("frame_o", frame_o, m_ctr == FT - 1);
            chk("wr_ready", wr_ready_o, m_ctr != FT - 1);
            if (pend_clamp || clamp_o) chk("clamp_o", clamp_o, pend_clamp);
            if (pend_err || ch_err_o)  chk("ch_err_o", ch_err_o, pend_err);
            pend_clamp = 1'b0;
            pend_err   = 1'b0;
            if (wr_valid_i && m_ctr != FT - 1) begin
                ch = int'(wr_ch_i);
                if (ch < NCH) begin
                    m_sh[ch]   = clampw(int'(wr_width_i));
                    pend_clamp = (int'(wr_width_i) < PMIN) || (int'(wr_width_i) > PMAX);
                end else begin
                    pend_err = 1'b1;
                end
            end
            for (int i = 0; i < NCH; i++)
                if (pwm_o[i]) begin
                    if (cnt[i] == 0) first[i] = m_ctr;
                    last[i] = m_ctr;
                    cnt[i]++;
                end
            if (m_ctr == FT - 1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    rec = sb_q.pop_front();
                    for (int i = 0; i < NCH; i++) begin
                        w = rec[8*i +: 8];
                        chk($sformatf("ch%0d_pulse", i),
                            {8'd0, 8'(cnt[i]), 8'(first[i]), 8'(last[i])},
                            {8'd0, w, (w != 0) ? 8'd1 : 8'd0, w});
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    m_act[i] = next_act(m_act[i], m_sh[i]);
                    cnt[i] = 0; first[i] = 0; last[i] = 0;
                end
                m_en = ch_en_i;
                sb_q.push_back(frame_rec());
            end
        end
    end

    task automatic wait_ctr(input int v);
        for (int k = 0; k < 2 * FT; k++) begin
            @(posedge clk_i); #1;
            if (m_ctr == v) return;
        end
        chk("wait_ctr_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input int ch, input int w, output int waits);
        bit done;
        done = 1'b0;
        waits = 0;
        wr_valid_i = 1'b1;
        wr_ch_i    = CHW'(ch);
        wr_width_i = CW'(w);
        for (int k = 0; k < 3 * FT && !done; k++) begin
            @(negedge clk_i);
            if (wr_ready_o) done = 1'b1;
            else waits++;
            @(posedge clk_i); #1;
        end
        wr_valid_i = 1'b0;
        if (!done) chk("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frames(input int n);
        repeat (n * FT) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pwm", pwm_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_clamp", clamp_o, 0);
        chk("rst_err", ch_err_o, 0);
        reset_i = 1'b0;
        run_frames(2);

        wait_ctr(40);
        wr(2, 12, w);
        wr(0, 20, w);
        run_frames(4);

        wr(1, 5, w);
        run_frames(1);
        wr(1, 30, w);
        run_frames(2);

        wait_ctr(FT - 1);
        wr(3, 18, w);
        chk("hold_wait", w, 1);
        run_frames(3);

        wait_ctr(30);
        wr(5, 14, w);
        run_frames(2);

        wait_ctr(20);
        wr(0, 11, w);
        wr(0, 19, w);
        wait_ctr(60);
        ch_en_i = 4'b1011;
        run_frames(2);
        ch_en_i = '1;
        wr(2, PMIN, w);
        wr(3, PMAX, w);
        run_frames(3);

        wait_ctr(5);
        chk("pre_rst_pwm", pwm_o, m_en);
        reset_i = 1'b1;
        #1;
        chk("rst_async_pwm", pwm_o, 0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        run_frames(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc_servo_multi_pwm.md
Name: rc_servo_multi_pwm

Overview:
N-channel RC-servo PWM generator: one shared frame counter drives NUM_CH pulse outputs.
- Per-channel pulse widths are written through a valid/ready command port into shadow registers.
- Written widths are clamped to the legal servo range.
- Shadow values are committed to the active registers only at the frame boundary, so pulses are never torn mid-frame.
- Sits between the position-control logic and the servo pins; direct successor to the fixed two-channel, two-width servo core.

Parameters:
NUM_CH, 4, number of servo channels (1..16)
CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_CH
CNT_WIDTH, 20, counter and width-register bit width
FRAME_TICKS, 1_000_000, frame period in clk_i cycles (20 ms at 50 MHz)
PULSE_MIN_TICKS, 50_000, minimum legal pulse (1.0 ms)
PULSE_MAX_TICKS, 100_000, maximum legal pulse (2.0 ms)
PULSE_RST_TICKS, 75_000, width loaded at reset (1.5 ms, neutral)
SLEW_STEP, 500, max width change per frame (used only with the optional feature)

Ports:
clk_i  in  1  clock, 50 MHz nominal
reset_i  in  1  asynchronous active-high reset
wr_valid_i  in  1  width-write request
wr_ready_o  out  1  port can accept a write this cycle
wr_ch_i  in  CH_W  target channel index
wr_width_i  in  CNT_WIDTH  requested pulse width in ticks
ch_en_i  in  NUM_CH  per-channel output enable; sampled at commit
pwm_o  out  NUM_CH  PWM outputs
frame_o  out  1  one-cycle pulse on the commit cycle
clamp_o  out  1  one-cycle pulse, registered, when an accepted write was clamped
ch_err_o  out  1  one-cycle pulse, registered, when an accepted write had wr_ch_i >= NUM_CH

Behaviour:
- Reset (async assert, sync release), all flops:
  - ctr=0; shadow[i]=active[i]=PULSE_RST_TICKS; en_act=0.
  - pwm_o=0, frame_o=0, clamp_o=0, ch_err_o=0.
- Frame counter: ctr counts 0..FRAME_TICKS-1, then wraps to 0. The commit cycle is the cycle in which ctr==FRAME_TICKS-1.
- Handshake:
  - wr_ready_o = ~commit cycle (combinational from ctr).
  - A write is accepted when wr_valid_i & wr_ready_o.
  - Data must be held stable while valid is high and ready is low.
  - On accept, shadow[wr_ch_i] <= clamp(wr_width_i).
  - Clamp: below PULSE_MIN_TICKS → MIN; above PULSE_MAX_TICKS → MAX; either case pulses clamp_o next cycle.
  - wr_ch_i >= NUM_CH: write discarded, ch_err_o pulses, no shadow changes.
  - Multiple writes to one channel within a frame: the last accepted write wins.
- Commit, at the edge ending the commit cycle:
  - active[i] <= shadow[i]; en_act <= ch_en_i.
  - frame_o is high during the commit cycle (registered, asserted from the previous edge).
- PWM output: pwm_o[i] <= en_act[i] & (ctr < active[i]), registered.
  - The output lags ctr by 1 cycle, so it is high for exactly active[i] consecutive cycles, starting the cycle after ctr==0.
  - Disabled channel: constant 0.
- First frame after reset: en_act=0, so all outputs stay low until the first commit.
- Mid-frame reset: outputs drop to 0 immediately (async); the frame restarts at ctr=0.
- All compares are unsigned, CNT_WIDTH bits. Parameter constraints: FRAME_TICKS <= 2**CNT_WIDTH and PULSE_MAX_TICKS < FRAME_TICKS.

Optional Feature:
Macro RC_SERVO_SLEW_EN.
- Defined: at commit, active[i] moves toward shadow[i] by at most SLEW_STEP: active += min(SLEW_STEP, |shadow-active|), with the sign following the direction of shadow-active. Convergence takes multiple frames.
- Undefined: active[i] <= shadow[i] directly; SLEW_STEP is unused.

Decomposition:
- Package rc_servo_pkg holds:
  - default timing constants CLK_HZ, FRAME_TICKS, PULSE_MIN/MAX/RST_TICKS;
  - clamp function.
- One sub-module, rc_servo_pwm_ch:
  - per-channel active register, optional slew logic, compare/output flop;
  - instantiated NUM_CH times by a generate loop.
- The top level owns the shared counter, handshake, shadow registers, and error/clamp flags.

Test Plan:
Sim params for all scenarios: FRAME_TICKS=100, MIN=10, MAX=20, RST=15, SLEW_STEP=2, NUM_CH=4.
1. Reset, ch_en_i=4'hF, no writes → frame 1 all pwm_o low; from frame 2 each pwm_o is high 15 cycles starting 1 cycle after ctr==0; frame_o pulses every 100 cycles.
2. Write ch2=12 at ctr=40 → ch2 keeps 15 for the current frame, becomes 12 from the next frame; other channels unchanged.
3. Write ch1=5, then ch1=30 → clamp_o pulses once per write; active widths become 10 and then 20 in successive frames.
4. Hold wr_valid_i through the commit cycle → wr_ready_o is low for exactly that cycle; the write is accepted on the following cycle and applies in the frame after next.
5. Write ch=5 (NUM_CH=4) → ch_err_o pulses once; no channel width changes.
6. With RC_SERVO_SLEW_EN: write ch0=20 from 15 → ch0 widths over successive frames are 17, 19, 20. Also assert reset_i mid-pulse → pwm_o drops to 0 in the same cycle.
